// File: rtl/aux_uart_bridge_if.sv
// rtl/aux_uart_bridge_if.sv - aux bus and uart stream signals for aux_uart_bridge
interface aux_uart_bridge_if;
  logic [15:0] aux_adr_i;
  logic [7:0]  aux_dat_i;
  logic [7:0]  aux_dat_o;
  logic        aux_we_i;
  logic        aux_re_i;
  logic        aux_sel_o;
  logic [7:0]  tx_tdata_o;
  logic        tx_tvalid_o;
  logic        tx_tready_i;
  logic [7:0]  rx_tdata_i;
  logic        rx_tvalid_i;
  logic        rx_tready_o;
  logic [15:0] prescale_o;
  logic        irq_o;

  modport master (
    output aux_adr_i, aux_dat_i, aux_we_i, aux_re_i, tx_tready_i, rx_tdata_i, rx_tvalid_i,
    input  aux_dat_o, aux_sel_o, tx_tdata_o, tx_tvalid_o, rx_tready_o, prescale_o, irq_o
  );

  modport slave (
    input  aux_adr_i, aux_dat_i, aux_we_i, aux_re_i, tx_tready_i, rx_tdata_i, rx_tvalid_i,
    output aux_dat_o, aux_sel_o, tx_tdata_o, tx_tvalid_o, rx_tready_o, prescale_o, irq_o
  );
endinterface

// File: rtl/aux_uart_bridge.sv
// rtl/aux_uart_bridge.sv - aux-bus UART bridge with TX/RX byte FIFOs, status and prescale
// Optional CTRL register and interrupt enabled by defining AUX_UART_IRQ_EN.
module aux_uart_bridge #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          FIFO_AW      = 4,
  parameter logic [15:0] PRESCALE_RST = 16'd1
) (
  input logic               clk,
  input logic               reset_n,
  aux_uart_bridge_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]       tx_mem [DEPTH];
  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic             we_prev, re_prev;
  logic             rx_ovf, tx_ovf, rx_ready;
  logic [15:0]      presc;
  logic [7:0]       ctrl_rd;
  logic [7:0]       rd_data;

  logic       sel, wr_edge, rd_edge;
  logic [2:0] off;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_pop, tx_push_req, tx_push, tx_ovf_set;
  logic       rx_pop, rx_push_req, rx_push, rx_ovf_set;
  logic       status_wr;
  logic [7:0] status;

  assign sel     = (bus.aux_adr_i[15:3] == BASE_ADDR[15:3]);
  assign off     = bus.aux_adr_i[2:0];
  assign wr_edge = bus.aux_we_i & sel & ~we_prev;
  assign rd_edge = bus.aux_re_i & sel & ~re_prev;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                    (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                    (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);

  // A push onto a full FIFO still lands when the same cycle frees a slot.
  assign tx_pop      = ~tx_empty & bus.tx_tready_i;
  assign tx_push_req = wr_edge & (off == 3'd0);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;

  assign rx_pop      = rd_edge & (off == 3'd0) & ~rx_empty;
  assign rx_push_req = bus.rx_tvalid_i & rx_ready;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign rx_ovf_set  = rx_push_req & rx_full & ~rx_pop;

  assign status_wr = wr_edge & (off == 3'd1);
  assign status    = {3'b000, tx_ovf, tx_empty, rx_ovf, ~tx_full, ~rx_empty};

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= bus.aux_dat_i;
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= bus.rx_tdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      we_prev  <= 1'b0;
      re_prev  <= 1'b0;
      rx_ovf   <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_ready <= 1'b0;
      presc    <= PRESCALE_RST;
    end else begin
      we_prev  <= bus.aux_we_i & sel;
      re_prev  <= bus.aux_re_i & sel;
      rx_ready <= 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_ovf_set)                       rx_ovf <= 1'b1;
      else if (status_wr && bus.aux_dat_i[2]) rx_ovf <= 1'b0;
      if (tx_ovf_set)                       tx_ovf <= 1'b1;
      else if (status_wr && bus.aux_dat_i[4]) tx_ovf <= 1'b0;
      if (wr_edge && off == 3'd2) presc[7:0]  <= bus.aux_dat_i;
      if (wr_edge && off == 3'd3) presc[15:8] <= bus.aux_dat_i;
    end
  end

`ifdef AUX_UART_IRQ_EN
  logic [1:0] ctrl;
  logic       irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl  <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      if (wr_edge && off == 3'd4) ctrl <= bus.aux_dat_i[1:0];
      irq_q <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty) | rx_ovf;
    end
  end

  assign ctrl_rd   = {6'b000000, ctrl};
  assign bus.irq_o = irq_q;
`else
  assign ctrl_rd   = 8'h00;
  assign bus.irq_o = 1'b0;
`endif

  always_comb begin
    rd_data = 8'h00;
    case (off)
      3'd0:    rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];
      3'd1:    rd_data = status;
      3'd2:    rd_data = presc[7:0];
      3'd3:    rd_data = presc[15:8];
      3'd4:    rd_data = ctrl_rd;
      default: rd_data = 8'h00;
    endcase
  end

  assign bus.aux_dat_o   = rd_data;
  assign bus.aux_sel_o   = sel;
  assign bus.tx_tdata_o  = tx_mem[tx_rp[FIFO_AW-1:0]];
  assign bus.tx_tvalid_o = ~tx_empty;
  assign bus.rx_tready_o = rx_ready;
  assign bus.prescale_o  = presc;

endmodule

// File: tb/tb_aux_uart_bridge.sv
// tb/tb_aux_uart_bridge.sv - scoreboard bench for aux_uart_bridge (default or AUX_UART_IRQ_EN build)
module tb_aux_uart_bridge;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] A_DATA = BASE + 16'd0;
  localparam logic [15:0] A_STAT = BASE + 16'd1;
  localparam logic [15:0] A_PLO  = BASE + 16'd2;
  localparam logic [15:0] A_PHI  = BASE + 16'd3;
  localparam logic [15:0] A_CTRL = BASE + 16'd4;
  localparam logic [15:0] A_RSV  = BASE + 16'd5;

  typedef struct {
    logic [7:0] v;
    string      n;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t rd_q[$];
  logic [7:0] tx_q[$];
  logic re_seen = 1'b0;

  aux_uart_bridge_if bus ();

  aux_uart_bridge #(
    .BASE_ADDR(BASE), .FIFO_AW(4), .PRESCALE_RST(16'd1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares CPU read data on the first read cycle and every TX stream transfer.
  always @(negedge clk) begin
    if (bus.aux_re_i && bus.aux_sel_o && !re_seen) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected act=%0h", bus.aux_dat_o);
      end else begin
        chk(rd_q[0].n, bus.aux_dat_o, rd_q[0].v);
        void'(rd_q.pop_front());
      end
    end
    re_seen <= bus.aux_re_i;
    if (reset_n && bus.tx_tvalid_o && bus.tx_tready_i) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected act=%0h", bus.tx_tdata_o);
      end else begin
        chk("tx_byte", bus.tx_tdata_o, tx_q[0]);
        void'(tx_q.pop_front());
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold = 1);
    @(posedge clk); #1;
    bus.aux_adr_i = a;
    bus.aux_dat_i = d;
    bus.aux_we_i  = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.aux_we_i = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] e, input string n, input int hold = 1);
    exp_t x;
    x.v = e;
    x.n = n;
    rd_q.push_back(x);
    @(posedge clk); #1;
    bus.aux_adr_i = a;
    bus.aux_re_i  = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.aux_re_i = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_tdata_i  = b;
    bus.rx_tvalid_i = 1'b1;
    @(posedge clk); #1;
    bus.rx_tvalid_i = 1'b0;
  endtask

  task automatic tx_drain(input int cycles);
    @(posedge clk); #1 bus.tx_tready_i = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 bus.tx_tready_i = 1'b0;
  endtask

  initial begin
    bus.aux_adr_i   = 16'h0000;
    bus.aux_dat_i   = 8'h00;
    bus.aux_we_i    = 1'b0;
    bus.aux_re_i    = 1'b0;
    bus.tx_tready_i = 1'b0;
    bus.rx_tdata_i  = 8'h00;
    bus.rx_tvalid_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_tvalid", bus.tx_tvalid_o, 1'b0);
    chk("rst_rx_tready", bus.rx_tready_o, 1'b0);
    chk("rst_irq", bus.irq_o, 1'b0);
    chk("rst_prescale", bus.prescale_o, 16'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rx_tready_after_rst", bus.rx_tready_o, 1'b1);

    cpu_read(A_STAT, 8'h0A, "rst_status");
    cpu_read(A_PLO, 8'h01, "rst_presc_lo");
    cpu_read(A_PHI, 8'h00, "rst_presc_hi");

    // TX path with back-pressure, then release
    cpu_write(A_DATA, 8'h41); tx_q.push_back(8'h41);
    cpu_write(A_DATA, 8'h42); tx_q.push_back(8'h42);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("tx_hold_valid", bus.tx_tvalid_o, 1'b1);
      chk("tx_hold_data", bus.tx_tdata_o, 8'h41);
    end
    tx_drain(4);
    @(negedge clk);
    chk("tx_idle_valid", bus.tx_tvalid_o, 1'b0);
    cpu_read(A_STAT, 8'h0A, "status_after_tx");

    // TX overflow: 17 writes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      cpu_write(A_DATA, 8'h60 + 8'(i));
      if (i < 16) tx_q.push_back(8'h60 + 8'(i));
    end
    cpu_read(A_STAT, 8'h10, "status_tx_full_ovf");
    cpu_write(A_STAT, 8'h10);
    cpu_read(A_STAT, 8'h00, "status_tx_ovf_clr");
    tx_drain(20);
    @(negedge clk);
    chk("tx_drained", bus.tx_tvalid_o, 1'b0);

    // RX path
    rx_send(8'h55);
    rx_send(8'hAA);
    cpu_read(A_STAT, 8'h0B, "status_rx_ne");
    cpu_read(A_DATA, 8'h55, "rx_0x55");
    cpu_read(A_DATA, 8'hAA, "rx_0xAA");
    cpu_read(A_DATA, 8'h00, "rx_empty_read");
    cpu_read(A_STAT, 8'h0A, "status_rx_empty");

    // RX overflow: 17 consecutive beats
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      bus.rx_tdata_i  = 8'h80 + 8'(i);
      bus.rx_tvalid_i = 1'b1;
    end
    @(posedge clk); #1 bus.rx_tvalid_i = 1'b0;
    cpu_read(A_STAT, 8'h0F, "status_rx_ovf");
    cpu_write(A_STAT, 8'h04);
    cpu_read(A_STAT, 8'h0B, "status_rx_ovf_clr");

    // Push onto a full RX FIFO in the same cycle as a CPU pop
    rd_q.push_back('{v: 8'h80, n: "rx_pop_with_push"});
    @(posedge clk); #1;
    bus.aux_adr_i   = A_DATA;
    bus.aux_re_i    = 1'b1;
    bus.rx_tdata_i  = 8'h90;
    bus.rx_tvalid_i = 1'b1;
    @(posedge clk); #1;
    bus.aux_re_i    = 1'b0;
    bus.rx_tvalid_i = 1'b0;
    cpu_read(A_STAT, 8'h0B, "status_no_ovf_on_swap");

    // Held read strobe pops once; remaining bytes come out in order across the wrap
    cpu_read(A_DATA, 8'h81, "rx_held_read", 4);
    for (int i = 2; i < 16; i++) cpu_read(A_DATA, 8'h80 + 8'(i), "rx_order");
    cpu_read(A_DATA, 8'h90, "rx_wrap_last");
    cpu_read(A_DATA, 8'h00, "rx_empty_again");

    // Prescale and reserved registers
    cpu_write(A_PLO, 8'h34);
    cpu_write(A_PHI, 8'h12);
    @(negedge clk);
    chk("prescale_o", bus.prescale_o, 16'h1234);
    cpu_read(A_PLO, 8'h34, "presc_lo_rb");
    cpu_read(A_PHI, 8'h12, "presc_hi_rb");
    cpu_write(A_RSV, 8'hFF);
    cpu_read(A_RSV, 8'h00, "reserved_read");

`ifdef AUX_UART_IRQ_EN
    cpu_write(A_CTRL, 8'h01);
    cpu_read(A_CTRL, 8'h01, "ctrl_rb");
    @(negedge clk);
    chk("irq_idle", bus.irq_o, 1'b0);
    rx_send(8'h33);
    @(posedge clk); #1;
    chk("irq_rx", bus.irq_o, 1'b1);
    cpu_read(A_DATA, 8'h33, "irq_rx_byte");
    @(posedge clk); #1;
    chk("irq_cleared", bus.irq_o, 1'b0);
    cpu_write(A_CTRL, 8'h00);
`else
    cpu_write(A_CTRL, 8'h03);
    cpu_read(A_CTRL, 8'h00, "ctrl_absent");
    rx_send(8'h33);
    @(posedge clk); #1;
    chk("irq_tied_low", bus.irq_o, 1'b0);
    cpu_read(A_DATA, 8'h33, "rx_byte_noirq");
`endif

    // Held write strobe pushes once
    cpu_write(A_DATA, 8'h77, 3);
    tx_q.push_back(8'h77);
    tx_drain(5);
    cpu_read(A_STAT, 8'h0A, "status_after_held_wr");

    // Reset mid-transfer discards queued bytes
    cpu_write(A_DATA, 8'hE1);
    cpu_write(A_DATA, 8'hE2);
    @(negedge clk);
    chk("pre_reset_valid", bus.tx_tvalid_o, 1'b1);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("reset_valid", bus.tx_tvalid_o, 1'b0);
    chk("reset_prescale", bus.prescale_o, 16'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    tx_drain(4);
    cpu_read(A_STAT, 8'h0A, "status_after_reset");

    repeat (3) @(posedge clk);
    chk("tx_queue_empty", tx_q.size(), 0);
    chk("rd_queue_empty", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aux_uart_bridge.md
Name: aux_uart_bridge

Overview:
- Memory-mapped UART bridge on the PIC core's aux bus; sits downstream of the CPU aux port and upstream of the uart module's AXI-stream ports.
- Provides TX/RX byte FIFOs, sticky status flags and a writable baud prescale, so firmware can do buffered serial I/O with flow control.
- The top level drives the aux_dat_io tristate: aux_dat_o is placed on the bus when aux_sel_o=1 and aux_we_i=0.

Parameters:
- BASE_ADDR, 16'hFF00, aux address of register 0; bits [2:0] must be 0.
- FIFO_AW, 4, log2 of depth for each FIFO (default 16 entries).
- PRESCALE_RST, 16'd1, reset value of the prescale register.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- aux_adr_i  in  16  aux address.
- aux_dat_i  in  8  aux write data.
- aux_dat_o  out  8  aux read data; combinational from address.
- aux_we_i  in  1  aux write strobe.
- aux_re_i  in  1  aux read strobe.
- aux_sel_o  out  1  address hit in the 8-byte window.
- tx_tdata_o  out  8  byte to uart input_axis_tdata.
- tx_tvalid_o  out  1  TX FIFO not empty.
- tx_tready_i  in  1  uart input_axis_tready.
- rx_tdata_i  in  8  uart output_axis_tdata.
- rx_tvalid_i  in  1  uart output_axis_tvalid.
- rx_tready_o  out  1  always 1 out of reset.
- prescale_o  out  16  to uart prescale.
- irq_o  out  1  interrupt request (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0):
  - Both FIFOs empty; sticky flags, CTRL and edge detectors cleared; prescale_o=PRESCALE_RST.
  - tx_tvalid_o=0, rx_tready_o=0, irq_o=0.
  - Reset mid-transfer discards all FIFO contents.
- Decode: aux_sel_o = (aux_adr_i[15:3]==BASE_ADDR[15:3]); offset = aux_adr_i[2:0].
- Strobe edges: a write acts once, on the first cycle aux_we_i=1 with aux_sel_o=1 (registered previous-strobe detect). A read side-effect acts once, on the first cycle of aux_re_i. Held strobes do not repeat.
- Register map:
  - +0 DATA
    - Write: push to the TX FIFO. If the FIFO is full, the byte is dropped and TX_OVF is set.
    - Read: returns the RX head; 8'h00 if empty. Pops on the read edge; a pop on empty is ignored.
  - +1 STATUS, read-only except W1C:
    - b0 RX_NE, b1 TX_NF, b2 RX_OVF (sticky), b3 TX_EMPTY, b4 TX_OVF (sticky), b7:5=0.
    - Writing 1 to b2/b4 clears that flag. If a set event and a clear land in the same cycle, set wins.
  - +2 PRESC_LO, +3 PRESC_HI: R/W; take effect the next cycle.
  - +4 CTRL: see Optional Feature.
  - +5..+7: read 8'h00, writes ignored.
- TX stream:
  - tx_tvalid_o=!tx_empty; tx_tdata_o = head entry.
  - Pop when tvalid&tready.
  - Data is held stable while tvalid=1 and tready=0.
- RX stream:
  - rx_tready_o=1 after reset.
  - On rx_tvalid_i: push if not full; if full, drop the byte and set RX_OVF.
- FIFO rules:
  - Pointers are FIFO_AW+1 bits; full/empty come from the MSB compare; wrap-around is natural.
  - Simultaneous push and pop on the same FIFO are both performed. When full, this push succeeds and no overflow is flagged. When empty, the pop is ignored and the push succeeds.
  - Counts are updated in the same cycle as the push/pop; flags are visible the next cycle.
- Latency:
  - CPU write to DATA → tx_tvalid_o high 1 cycle later.
  - rx_tvalid_i → RX_NE visible on STATUS 1 cycle later.

Optional Feature:
- Macro AUX_UART_IRQ_EN.
- Defined:
  - CTRL +4 b0 RXIE, b1 TXIE, R/W, reset 0.
  - irq_o registered = (RXIE&RX_NE) | (TXIE&TX_EMPTY) | RX_OVF.
- Undefined:
  - CTRL reads 8'h00, writes ignored.
  - irq_o tied 0; no CTRL flops.

Test Plan:
- Reset defaults: after reset, read STATUS → 8'h0A (TX_NF, TX_EMPTY); PRESC_LO/HI → 8'h01/8'h00; prescale_o=16'd1.
- TX path: write 0x41,0x42 to DATA with tx_tready_i=0 for 5 cycles → tx_tvalid_o=1, tx_tdata_o=0x41 held. Then tready=1 → 0x41 then 0x42 transferred; tx_tvalid_o=0; STATUS b3=1.
- TX overflow: write 17 bytes with tready=0 (depth 16) → TX_NF=0, TX_OVF=1; byte 17 never emitted. Write 8'h10 to STATUS → TX_OVF=0.
- RX path and overflow: inject 0x55,0xAA on rx_tvalid_i → DATA reads 0x55 then 0xAA, then 0x00 with RX_NE=0. Inject 17 bytes → RX_OVF=1; first 16 are read back in order.
- Strobe handling: hold aux_re_i on DATA for 4 cycles with 3 bytes queued → exactly one pop. Simultaneous RX push on full with a CPU pop → no RX_OVF; order preserved across pointer wrap.
- With AUX_UART_IRQ_EN: set CTRL=8'h01, inject one RX byte → irq_o=1 within 2 cycles; read DATA → irq_o=0. Without the macro: irq_o stays 0 and CTRL reads 8'h00.
